// File: rtl/serial_add_arb_if.sv
// rtl/serial_add_arb_if.sv - request/operand/result bundle for the bit-serial shared adder
interface serial_add_arb_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             cin0;
  logic             cin1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             owner;

  modport master (
    output req0, req1, a0, b0, a1, b1, cin0, cin1,
    input  gnt0, gnt1, busy, done, sum, cout, owner
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, cin0, cin1,
    output gnt0, gnt1, busy, done, sum, cout, owner
  );
endinterface

// File: rtl/serial_add_arb.sv
// rtl/serial_add_arb.sv - two-requester round-robin arbiter over one bit-serial full adder
module serial_add_arb #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_add_arb_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             cur_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             owner_q;

  logic grant;
  logic win;
  logic gnt0, gnt1, busy, done;
  logic fa_s, fa_c;

  // The single shared full-adder cell.
  assign fa_s = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    grant   = 1'b0;
    win     = prio_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        // rst_n gating keeps grants low during an asserted async reset.
        if (rst_n && (bus.req0 || bus.req1)) begin
          grant   = 1'b1;
          win     = (bus.req0 && bus.req1) ? prio_q : bus.req1;
          gnt0    = ~win;
          gnt1    = win;
          prio_d  = ~win;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  // a_q doubles as the result shift register: sum bits enter at the MSB as operand bits leave the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cur_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      owner_q <= 1'b0;
    end else if (grant) begin
      a_q     <= win ? bus.a1 : bus.a0;
      b_q     <= win ? bus.b1 : bus.b0;
      carry_q <= win ? bus.cin1 : bus.cin0;
      cnt_q   <= '0;
      cur_q   <= win;
    end else if (state_q == RUN) begin
      a_q     <= {fa_s, a_q[WIDTH-1:1]};
      b_q     <= b_q >> 1;
      carry_q <= fa_c;
      cnt_q   <= cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        sum_q   <= {fa_s, a_q[WIDTH-1:1]};
        cout_q  <= fa_c;
        owner_q <= cur_q;
      end
    end
  end

  assign bus.gnt0  = gnt0;
  assign bus.gnt1  = gnt1;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.owner = owner_q;

endmodule

// File: tb/tb_serial_add_arb.sv
// tb/tb_serial_add_arb.sv - scoreboard bench for serial_add_arb
module tb_serial_add_arb;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_add_arb_if #(.WIDTH(W)) bus ();
  serial_add_arb #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic         r0, r1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         c0, c1;
    logic         eown;
    logic [W:0]   eres;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rem = 0;
  int done_cnt = 0;
  int gnt_cnt = 0;
  int last_gnt_cyc = 0;
  logic prio_m = 1'b0;
  logic [W+1:0] sb[$];
  logic [W+1:0] exp_last = '0;
  int gnt_cyc_q[$];
  logic gnt_who_q[$];
  logic v, w;
  logic [W:0] res;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: round-robin pointer, busy window and result scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("reset_outputs", {bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.cout, bus.owner, bus.sum}, 0);
      rem = 0;
      prio_m = 1'b0;
      sb.delete();
      exp_last = '0;
    end else begin
      chk("busy", bus.busy, rem > 0);
      chk("done", bus.done, rem == 1);
      if (rem > 0) begin
        chk("gnt_outside_idle", {bus.gnt0, bus.gnt1}, 0);
        rem--;
      end else begin
        v = bus.req0 | bus.req1;
        w = (bus.req0 && bus.req1) ? prio_m : bus.req1;
        chk("gnt", {bus.gnt0, bus.gnt1}, v ? (w ? 2'b01 : 2'b10) : 2'b00);
        if (v) begin
          res = w ? (bus.a1 + bus.b1 + bus.cin1) : (bus.a0 + bus.b0 + bus.cin0);
          sb.push_back({w, res});
          prio_m = ~w;
          rem = W + 1;
          gnt_cnt++;
          last_gnt_cyc = cyc;
          gnt_cyc_q.push_back(cyc);
          gnt_who_q.push_back(w);
        end
      end
      if (bus.done) begin
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) exp_last = sb.pop_front();
        chk("latency", cyc - last_gnt_cyc, W + 1);
        done_cnt++;
      end
      chk("result", {bus.owner, bus.cout, bus.sum}, exp_last);
    end
  end

  task automatic wait_grant(input int g0);
    int n = 0;
    while (gnt_cnt == g0 && n < 5) begin
      @(posedge clk);
      n++;
    end
    chk("grant_seen", gnt_cnt - g0, 1);
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 3 * W) begin
      @(posedge clk);
      n++;
    end
    chk("done_seen", done_cnt - d0, 1);
  endtask

  task automatic do_op(input vec_t t, input string nm);
    int g0, d0;
    @(posedge clk); #1;
    bus.req0 = t.r0; bus.req1 = t.r1;
    bus.a0 = t.a0; bus.b0 = t.b0; bus.cin0 = t.c0;
    bus.a1 = t.a1; bus.b1 = t.b1; bus.cin1 = t.c1;
    g0 = gnt_cnt;
    d0 = done_cnt;
    wait_grant(g0);
    #1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    wait_done(d0);
    #1;
    chk(nm, {bus.owner, bus.cout, bus.sum}, {t.eown, t.eres});
  endtask

  vec_t vecs[7];

  initial begin
    int g0, g1, d0, n;
    vec_t t;
    bus.req0 = 0; bus.req1 = 0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    bus.cin0 = 0; bus.cin1 = 0;

    vecs[0] = '{1'b1, 1'b0, 8'h5A, 8'h3C, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 9'h096};
    vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 9'h1FF};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 9'h100};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 9'h001};
    vecs[4] = '{1'b1, 1'b1, 8'h10, 8'h20, 8'h01, 8'h02, 1'b0, 1'b1, 1'b1, 9'h004};
    vecs[5] = '{1'b1, 1'b1, 8'h10, 8'h20, 8'h01, 8'h02, 1'b0, 1'b1, 1'b0, 9'h030};
    vecs[6] = '{1'b1, 1'b0, 8'h80, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 9'h100};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // Both requesters held from reset: strict alternation every W+2 cycles.
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.req0 = 1; bus.req1 = 1;
    bus.a0 = 8'h11; bus.b0 = 8'h22; bus.cin0 = 0;
    bus.a1 = 8'hF0; bus.b1 = 8'h0F; bus.cin1 = 1;
    repeat (2) @(posedge clk);
    gnt_cyc_q.delete();
    gnt_who_q.delete();
    #1 rst_n = 1'b1;
    repeat (45) @(posedge clk);
    #1 bus.req0 = 0; bus.req1 = 0;
    chk("rr_count", gnt_who_q.size() >= 4, 1);
    if (gnt_who_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("rr_who%0d", i), gnt_who_q[i], i % 2);
      for (int i = 1; i < 4; i++) chk($sformatf("rr_space%0d", i), gnt_cyc_q[i] - gnt_cyc_q[i-1], W + 2);
    end
    repeat (2 * W) @(posedge clk);

    // req1 pulsed only while busy must never be granted.
    @(posedge clk); #1;
    bus.req0 = 1; bus.a0 = 8'h12; bus.b0 = 8'h34; bus.cin0 = 0;
    g0 = gnt_cnt;
    d0 = done_cnt;
    wait_grant(g0);
    #1 bus.req0 = 0; bus.req1 = 1;
    g1 = gnt_cnt;
    repeat (W) @(posedge clk);
    @(negedge clk); #1 bus.req1 = 0;
    wait_done(d0);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_req_ignored", gnt_cnt - g1, 0);
    chk("ignore_result", {bus.owner, bus.cout, bus.sum}, 10'h046);

    // Reset in the middle of RUN aborts without a done strobe.
    @(posedge clk); #1;
    bus.req0 = 1; bus.a0 = 8'h77; bus.b0 = 8'h11; bus.cin0 = 0;
    g0 = gnt_cnt;
    wait_grant(g0);
    #1 bus.req0 = 0;
    repeat (4) @(posedge clk);
    #1;
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_immediate", {bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.cout, bus.owner, bus.sum}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    t = '{1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 9'h002};
    do_op(t, "after_abort");

    // Random traffic, checked entirely by the scoreboard.
    g0 = gnt_cnt;
    n = 0;
    while (gnt_cnt - g0 < 1000 && n < 20000) begin
      @(posedge clk); #1;
      bus.req0 = ($urandom_range(0, 3) != 0);
      bus.req1 = ($urandom_range(0, 3) != 0);
      bus.a0 = W'($urandom); bus.b0 = W'($urandom); bus.cin0 = 1'($urandom);
      bus.a1 = W'($urandom); bus.b1 = W'($urandom); bus.cin1 = 1'($urandom);
      n++;
    end
    #1 bus.req0 = 0; bus.req1 = 0;
    chk("rand_ops", gnt_cnt - g0 >= 1000, 1);
    repeat (3 * W) @(posedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_add_arb.md
SERIAL_ADD_ARB -- requirements
Module: serial_add_arb

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, setting operand and result width in bits (legal range 2..32).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The module SHALL have ports req0 and req1, input, 1 bit each, operation request from requester 0 and requester 1.
REQ-005 The module SHALL have ports a0, b0, a1, b1, input, WIDTH each, operands of requester 0 and requester 1.
REQ-006 The module SHALL have ports cin0 and cin1, input, 1 bit each, carry-in of requester 0 and requester 1.
REQ-007 The module SHALL have ports gnt0 and gnt1, output, 1 bit each, acceptance strobes; operands are captured on the edge ending the strobe cycle.
REQ-008 The module SHALL have port busy, output, 1 bit, high while an accepted operation is in progress or completing.
REQ-009 The module SHALL have port done, output, 1 bit, one-cycle completion strobe.
REQ-010 The module SHALL have ports sum (WIDTH), cout (1) and owner (1), output, holding the last completed result, carry-out and requester index.

Function
REQ-011 The block SHALL contain exactly one 1-bit full-adder cell (sum = a^b^c, carry = majority(a,b,c)), shared by both requesters and used bit-serially, LSB first.
REQ-012 The control FSM SHALL have states IDLE, RUN and DONE; busy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-013 In IDLE with at least one req high, gnt SHALL be driven combinationally high for exactly one winner; at that edge the operands and cin of the winner are captured, the bit counter cleared, and state moves to RUN.
REQ-014 Arbitration SHALL be round-robin: a lone requester always wins; with both high, the requester not granted most recently wins; after reset requester 0 wins a tie.
REQ-015 gnt0 and gnt1 SHALL never be high together and SHALL be 0 outside IDLE; requests in RUN or DONE are ignored, not queued.
REQ-016 In RUN each edge SHALL add captured bit i of a and b with the carry register, shift the result bit into a WIDTH-bit shift register, and update the carry register; RUN lasts exactly WIDTH cycles.
REQ-017 On the edge ending the last RUN cycle, sum, cout and owner SHALL update together and state moves to DONE.
REQ-018 done SHALL be 1 for exactly the single DONE cycle, then state returns to IDLE; latency from the gnt cycle to the done cycle is WIDTH+1 cycles.
REQ-019 sum, cout and owner SHALL hold their values until the next completion, unaffected by input changes or new grants.
REQ-020 Arithmetic SHALL be {cout,sum} = a + b + cin modulo 2^(WIDTH+1).
REQ-021 Back-to-back service SHALL be possible: a req present in the IDLE cycle immediately after DONE is granted in that cycle (minimum spacing WIDTH+2 cycles between grants).

Reset
REQ-022 While rst_n is 0, outputs SHALL be immediately: busy=0, done=0, sum=0, cout=0, owner=0, gnt0=gnt1=0 (regardless of req), and the FSM SHALL be IDLE with the round-robin pointer favouring requester 0.
REQ-023 Reset asserted during RUN or DONE SHALL abort the operation with no done strobe and no result update; the first request after release is served normally.

Verification
REQ-024 WIDTH=8, req0 with a0=0x5A, b0=0x3C, cin0=0 -> gnt0 for 1 cycle, busy 9 cycles, done 9 cycles after gnt, sum=0x96, cout=0, owner=0.
REQ-025 req1 with a1=0xFF, b1=0xFF, cin1=1 -> sum=0xFF, cout=1, owner=1; then a1=0xFF, b1=0x01, cin1=0 -> sum=0x00, cout=1.
REQ-026 req0 and req1 both held continuously from reset -> grants alternate 0,1,0,1 with grant spacing exactly 10 cycles; owner alternates to match.
REQ-027 req1 pulsed during RUN and DONE only -> never granted; gnt0/gnt1 stay 0 until IDLE.
REQ-028 rst_n low for 1 cycle at RUN bit 4 -> all outputs 0 at once, no done; after release req0 with a0=0x01, b0=0x01 -> sum=0x02, cout=0.
REQ-029 Random operands for both requesters, 1000 operations -> every {cout,sum} matches a+b+cin and owner matches the granted requester.
